// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: resynchronises toggle-qualified scan-code bytes and tracks a configurable key table.
// Latency: a toggle flip sampled into the first sync flop at edge k updates outputs at edge k+2.
// Backpressure: none; PS/2 byte spacing (~1 ms) guarantees at least 3 cycles between byte events.
module ps2_key_tracker #(
  parameter int                      NUM_KEYS       = 3,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES      = {9'h175, 9'h16B, 9'h029},
  parameter bit                      REPEAT_EN      = 1'b0,
  parameter int                      TIMEOUT_CYCLES = 400000
) (
  input  logic                clk_40MHz,
  input  logic                rst,
  input  logic [7:0]          ps2_byte,
  input  logic                ps2_toggle,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                seq_error
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  // Flops
  logic                tog_s1_q, tog_s2_q, tog_s3_q;
  logic [7:0]          byte_q, byte_d;
  state_t              state_q, state_d;
  logic [2:0]          pause_q, pause_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q, rel_d;
  logic                err_q, err_d;

  // Decoder actions for the current cycle
  logic                byte_evt;
  logic                do_make;
  logic                do_break;
  logic                code_ext;
  logic                bat_clr;
  logic [TO_W-1:0]     to_inc;

  // A new byte is present when the toggle has moved between the 2nd and 3rd sync stages;
  // the byte is taken straight from the receiver only in that cycle, otherwise the last one is held.
  always_comb begin
    byte_evt = tog_s2_q ^ tog_s3_q;
    byte_d   = byte_evt ? ps2_byte : byte_q;
  end

  // Sequence parser: prefix tracking, pause discard and prefix timeout.
  always_comb begin
    state_d  = state_q;
    pause_d  = pause_q;
    to_d     = to_q;
    err_d    = 1'b0;
    do_make  = 1'b0;
    do_break = 1'b0;
    code_ext = 1'b0;
    bat_clr  = 1'b0;
    to_inc   = to_q + 1'b1;

    if (byte_evt) begin
      // Any byte restarts the prefix timer and takes priority over a coincident timeout.
      to_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (byte_d)
            8'hE0: state_d = ST_EXT;
            8'hF0: state_d = ST_BRK;
            8'hE1: begin
              state_d = ST_PAUSE;
              pause_d = 3'd7;
            end
            8'hAA: bat_clr = 1'b1;
            8'hFA, 8'hFE, 8'h00, 8'hFF: ;
            default: do_make = 1'b1;
          endcase
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (byte_d == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else if (byte_d == 8'hE0 || byte_d == 8'hE1) begin
            err_d = 1'b1;
          end else if (byte_d != 8'h12 && byte_d != 8'h59) begin
            // 12/59 after E0 are the fake-shift codes and are dropped silently
            do_make  = 1'b1;
            code_ext = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (byte_d == 8'hE0 || byte_d == 8'hE1 || byte_d == 8'hF0) begin
            err_d = 1'b1;
          end else begin
            do_break = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (byte_d == 8'hE0 || byte_d == 8'hE1 || byte_d == 8'hF0) begin
            err_d = 1'b1;
          end else if (byte_d != 8'h12 && byte_d != 8'h59) begin
            do_break = 1'b1;
            code_ext = 1'b1;
          end
        end
        ST_PAUSE: begin
          pause_d = pause_q - 3'd1;
          if (pause_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_inc == TO_LAST) begin
        state_d = ST_IDLE;
        to_d    = '0;
        err_d   = 1'b1;
      end else begin
        to_d = to_inc;
      end
    end else begin
      to_d = '0;
    end
  end

  // Key table: apply make/break to every matching entry, duplicates respond together.
  always_comb begin
    held_d  = held_q;
    press_d = '0;
    rel_d   = '0;
    if (bat_clr) begin
      held_d = '0;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEY_CODES[9*i +: 9] == {code_ext, byte_d}) begin
        if (do_make) begin
          if (!held_q[i]) begin
            held_d[i]  = 1'b1;
            press_d[i] = 1'b1;
          end else if (REPEAT_EN) begin
            press_d[i] = 1'b1;
          end
        end
        if (do_break && held_q[i]) begin
          held_d[i] = 1'b0;
          rel_d[i]  = 1'b1;
        end
      end
    end
  end

  // State register: synchronisers, parser state and registered outputs.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      tog_s1_q <= 1'b0;
      tog_s2_q <= 1'b0;
      tog_s3_q <= 1'b0;
      byte_q   <= '0;
      state_q  <= ST_IDLE;
      pause_q  <= '0;
      to_q     <= '0;
      held_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      tog_s1_q <= ps2_toggle;
      tog_s2_q <= tog_s1_q;
      tog_s3_q <= tog_s2_q;
      byte_q   <= byte_d;
      state_q  <= state_d;
      pause_q  <= pause_d;
      to_q     <= to_d;
      held_q   <= held_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      err_q    <= err_d;
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign seq_error   = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: two instances share stimulus, one without and one with typematic repeat.
// Bytes are driven on the falling edge; outputs are sampled on falling edges.
module tb_ps2_key_tracker;

  logic       clk_40MHz = 1'b0;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_toggle;

  logic [2:0] held_a, press_a, rel_a;
  logic       err_a;
  logic [2:0] held_b, press_b, rel_b;
  logic       err_b;

  int tests = 0;
  int fails = 0;

  always #5 clk_40MHz = ~clk_40MHz;

  ps2_key_tracker #(
    .REPEAT_EN      (1'b0),
    .TIMEOUT_CYCLES (100)
  ) u_dut_a (
    .clk_40MHz   (clk_40MHz),
    .rst         (rst),
    .ps2_byte    (ps2_byte),
    .ps2_toggle  (ps2_toggle),
    .key_held    (held_a),
    .key_press   (press_a),
    .key_release (rel_a),
    .seq_error   (err_a)
  );

  ps2_key_tracker #(
    .REPEAT_EN      (1'b1),
    .TIMEOUT_CYCLES (100)
  ) u_dut_b (
    .clk_40MHz   (clk_40MHz),
    .rst         (rst),
    .ps2_byte    (ps2_byte),
    .ps2_toggle  (ps2_toggle),
    .key_held    (held_b),
    .key_press   (press_b),
    .key_release (rel_b),
    .seq_error   (err_b)
  );

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Drive one byte and return on the falling edge right after its outputs register.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_40MHz);
    ps2_byte   = b;
    ps2_toggle = ~ps2_toggle;
    repeat (3) @(negedge clk_40MHz);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk_40MHz);
  endtask

  initial begin
    rst        = 1'b1;
    ps2_byte   = 8'h00;
    ps2_toggle = 1'b0;
    gap(3);
    check("rst_held",  held_a,  3'b000);
    check("rst_press", press_a, 3'b000);
    check("rst_rel",   rel_a,   3'b000);
    check("rst_err",   {2'b00, err_a}, 3'b000);
    rst = 1'b0;
    gap(2);

    // Space make with latency check: nothing after edge k+1, press after edge k+2.
    @(negedge clk_40MHz);
    ps2_byte   = 8'h29;
    ps2_toggle = ~ps2_toggle;
    @(posedge clk_40MHz);
    @(negedge clk_40MHz);
    @(negedge clk_40MHz);
    check("lat_k1_press", press_a, 3'b000);
    check("lat_k1_held",  held_a,  3'b000);
    @(negedge clk_40MHz);
    check("space_press", press_a, 3'b001);
    check("space_held",  held_a,  3'b001);
    gap(1);
    check("space_press_1cyc", press_a, 3'b000);
    send_byte(8'hF0);
    check("brk_prefix_quiet", rel_a, 3'b000);
    send_byte(8'h29);
    check("space_rel",  rel_a,  3'b001);
    check("space_held0", held_a, 3'b000);
    gap(1);
    check("space_rel_1cyc", rel_a, 3'b000);

    // Left arrow make, then typematic repeat.
    send_byte(8'hE0);
    send_byte(8'h6B);
    check("left_press_a", press_a, 3'b010);
    check("left_press_b", press_b, 3'b010);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check("left_rep_a",      press_a, 3'b000);
    check("left_rep_b",      press_b, 3'b010);
    check("left_rep_held_a", held_a,  3'b010);
    check("left_rep_held_b", held_b,  3'b010);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    check("left_rel_a",  rel_a,  3'b010);
    check("left_rel_b",  rel_b,  3'b010);
    check("left_held_a", held_a, 3'b000);

    // Non-extended codes sharing the arrow scan codes are not tracked.
    send_byte(8'h6B);
    check("kp4_press", press_a, 3'b000);
    check("kp4_held",  held_a,  3'b000);
    send_byte(8'h75);
    check("kp8_press", press_a, 3'b000);
    check("kp8_held",  held_a,  3'b000);
    send_byte(8'hE0);
    send_byte(8'h75);
    check("up_press", press_a, 3'b100);
    check("up_held",  held_a,  3'b100);

    // BAT completion clears held keys without release pulses.
    send_byte(8'h29);
    check("up_space_held", held_a, 3'b101);
    send_byte(8'hAA);
    check("bat_held", held_a, 3'b000);
    check("bat_rel",  rel_a,  3'b000);
    gap(1);
    check("bat_rel_next", rel_a, 3'b000);

    // Pause sequence is swallowed whole.
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h77);
    check("pause_held",  held_a, 3'b000);
    check("pause_rel",   rel_a,  3'b000);
    check("pause_err",   {2'b00, err_a}, 3'b000);
    send_byte(8'h29);
    check("post_pause_press", press_a, 3'b001);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("post_pause_rel", rel_a, 3'b001);

    // Prefix timeout: error registers at the 99th edge after E0 is taken.
    send_byte(8'hE0);
    gap(98);
    check("to_not_yet", {2'b00, err_a}, 3'b000);
    gap(1);
    check("to_err_a", {2'b00, err_a}, 3'b001);
    check("to_err_b", {2'b00, err_b}, 3'b001);
    gap(1);
    check("to_err_1cyc", {2'b00, err_a}, 3'b000);
    send_byte(8'h6B);
    check("to_then_6b_press", press_a, 3'b000);
    check("to_then_6b_held",  held_a,  3'b000);

    // Illegal prefix byte.
    send_byte(8'hE0);
    send_byte(8'hE0);
    check("e0e0_err", {2'b00, err_a}, 3'b001);
    gap(1);
    check("e0e0_err_1cyc", {2'b00, err_a}, 3'b000);

    // Reset mid-sequence with all keys held; the toggle is left at 1 with F0 on the bus.
    if (ps2_toggle) send_byte(8'hFA);
    send_byte(8'h29);
    send_byte(8'hE0);
    send_byte(8'h6B);
    send_byte(8'hE0);
    send_byte(8'h75);
    check("all_held", held_a, 3'b111);
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(negedge clk_40MHz);
    rst = 1'b1;
    @(negedge clk_40MHz);
    check("midrst_held",  held_a,  3'b000);
    check("midrst_press", press_a, 3'b000);
    check("midrst_rel",   rel_a,   3'b000);
    check("midrst_err",   {2'b00, err_a}, 3'b000);
    gap(2);
    rst = 1'b0;
    gap(5);
    // The stale toggle replays F0 once, so the next 29 is a break of an unheld key.
    check("stray_f0_err", {2'b00, err_a}, 3'b000);
    send_byte(8'h29);
    check("stray_f0_press", press_a, 3'b000);
    check("stray_f0_held",  held_a,  3'b000);
    send_byte(8'h29);
    check("fresh_press", press_a, 3'b001);
    check("fresh_held",  held_a,  3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised successor to the fixed 3-key PS/2 decoder.
- Takes raw PS/2 scan-code bytes from the 50 MHz receiver domain and resynchronises them into clk_40MHz.
- Parses set-2 make/break/extended/pause sequences and checks them against a configurable key table.
- Outputs per-key held state plus one-cycle press/release pulses for game logic, with typematic repeats optionally suppressed.

Parameters:
- NUM_KEYS, 3, number of tracked keys (1..16).
- KEY_CODES, {9'h175, 9'h16B, 9'h029}, packed NUM_KEYS x 9-bit table; entry i = bits [9i+8:9i]. Bit 8 = E0-extended, [7:0] = scan code. Defaults: idx0 space, idx1 left arrow, idx2 up arrow.
- REPEAT_EN, 0, 1 = typematic repeat makes also pulse key_press.
- TIMEOUT_CYCLES, 400000, clk_40MHz cycles a prefix state may wait for its next byte (10 ms).

Ports:
- clk_40MHz  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ps2_byte  input  8  last received byte; stable whenever ps2_toggle is stable
- ps2_toggle  input  1  inverts once per new byte (receiver domain, asynchronous here)
- key_held  output  NUM_KEYS  1 while key i is down
- key_press  output  NUM_KEYS  one-cycle pulse on make
- key_release  output  NUM_KEYS  one-cycle pulse on break
- seq_error  output  1  one-cycle pulse on prefix timeout or illegal prefix byte

Behaviour:
- Reset: rst high at a clk_40MHz edge clears all outputs, the FSM (-> IDLE), the timeout counter, the pause counter and the sync stages. The sync stages reset to 0, so a toggle already at 1 after reset produces one byte event.
- CDC: ps2_toggle passes through 3 flops s1->s2->s3. A byte event is s2 != s3. ps2_byte is captured into byte_q on the event cycle only; it is never sampled otherwise.
- Latency: a toggle change first sampled into s1 at edge k updates outputs at edge k+2 (registered). Minimum event spacing is 3 cycles; PS/2 timing (~1 ms/byte) guarantees it.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (discarding).
- IDLE:
  - E0 -> EXT
  - F0 -> BRK
  - E1 -> PAUSE, pause counter = 7
  - AA (BAT) -> clear key_held without release pulses, stay IDLE
  - FA, FE, 00, FF -> ignore
  - other byte b -> make(code {0,b})
- EXT: F0 -> EXT_BRK; E0/E1 -> seq_error, IDLE; 12 or 59 (fake shift) -> IDLE with no action; other b -> make({1,b}), IDLE.
- BRK: E0/E1/F0 -> seq_error, IDLE; b -> break({0,b}), IDLE.
- EXT_BRK: E0/E1/F0 -> seq_error, IDLE; 12 or 59 -> IDLE with no action; b -> break({1,b}), IDLE.
- PAUSE: decrement the counter per byte and ignore the bytes; at 0 -> IDLE. Pause is never a tracked key.
- make(c) for every i with KEY_CODES[i] == c:
  - key not held: set key_held[i], pulse key_press[i].
  - key already held: key_press[i] pulses only if REPEAT_EN = 1.
- break(c) for every i with KEY_CODES[i] == c:
  - key held: clear key_held[i], pulse key_release[i].
  - key not held: no action.
- Duplicate table entries all respond together. Codes not in the table change no output.
- Timeout:
  - Counter resets on every byte event and counts while in EXT/BRK/EXT_BRK/PAUSE.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE with a seq_error pulse.
  - Byte event and timeout in the same cycle: the byte wins and no error is raised.
- Pulses last exactly 1 cycle and are 0 in every other cycle. Multiple keys may pulse in the same cycle only through duplicate table entries.
- Reset in the middle of a sequence drops it. Its remaining bytes are parsed fresh from IDLE; e.g. a stray F0 after reset is treated as a normal break prefix.

Test Plan:
- Defaults, bytes 29, F0 29 → key_press = 001 for 1 cycle, key_held[0] = 1; then key_release = 001, key_held = 000.
- Bytes E0 6B, then E0 6B (repeat), REPEAT_EN = 0 → one key_press = 010. Re-run with REPEAT_EN = 1 → two pulses; key_held[1] stays 1. Then E0 F0 6B → key_release = 010.
- Non-extended 6B (keypad 4) and 75 → no output change. E0 75 → key_press = 100, confirming the extended match.
- Hold space and up, then send AA → key_held = 000 and no key_release pulses. E1 14 77 E1 F0 14 F0 77 → no outputs, FSM back in IDLE, then 29 → press[0].
- E0 followed by TIMEOUT_CYCLES idle cycles (override to 100) → seq_error pulse at cycle 99; following 6B → no press (non-extended). E0 E0 → seq_error.
- Assert rst with key_held = 111 and mid-way through an E0 F0 sequence → all outputs 0 on the next edge. Toggle latency check: output changes exactly 2 edges after s1 samples the flip.
